irq_controller: RTL and testbench

- Collects level interrupt lines from memory-mapped peripherals (timer IRQ, others), latches and masks them, and arbitrates by fixed priority.
- Presents a single request to the CPU with an acknowledge / end-of-interrupt handshake.
- On end-of-interrupt, returns a one-cycle read strobe to the serviced source so that source clears its own IRQ flag.
- Sits directly downstream of the timer and its sibling peripherals, and upstream of the CPU interrupt input.

---
 rtl/irq_controller_if.sv | 25 ++
 rtl/irq_controller.sv | 146 ++++++++++++++
 tb/tb_irq_controller.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/irq_controller_if.sv
// Bus bundle between the interrupt controller, its peripherals and the CPU.
// slave : seen from the controller; master : seen from the CPU/peripheral side.
interface irq_controller_if #(
  parameter int N_SRC = 4
);
  logic [N_SRC-1:0] irqIn;
  logic             read;
  logic             write;
  logic [1:0]       addr;
  logic [31:0]      dataIn;
  logic [31:0]      dataOut;
  logic             cpuIRQ;
  logic             intAck;
  logic [N_SRC-1:0] srcRead;

  modport slave (
    input  irqIn, read, write, addr, dataIn, intAck,
    output dataOut, cpuIRQ, srcRead
  );

  modport master (
    output irqIn, read, write, addr, dataIn, intAck,
    input  dataOut, cpuIRQ, srcRead
  );
endinterface

// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller: latches peripheral IRQs into PENDING,
// masks with ENABLE, raises one CPU request, and on EOI pulses srcRead to the
// serviced source. Index 0 has the highest priority.
// Build option IRQC_EDGE_EN: when defined, PENDING sets on irqIn rising edges;
// otherwise PENDING sets every cycle an irqIn line is high (level mode).
module irq_controller #(
  parameter int N_SRC = 4
) (
  input  logic             clk,
  input  logic             rst,
  irq_controller_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  localparam logic [1:0] A_ENABLE  = 2'd0;
  localparam logic [1:0] A_PENDING = 2'd1;
  localparam logic [1:0] A_ID      = 2'd2;
  localparam logic [1:0] A_EOI     = 2'd3;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] enable_q, enable_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] srcRead_q, srcRead_d;
  logic [2:0]       id_q, id_d;
  logic [31:0]      dataOut_q, dataOut_d;

  logic [N_SRC-1:0] set_vec;
  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] ack_clr;
  logic [2:0]       win;
  logic             eoi;
  logic             ack_take;
  logic             unused_data;

  // Lowest set index wins.
  function automatic logic [2:0] pick_winner(input logic [N_SRC-1:0] c);
    logic [2:0] w;
    w = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (c[i]) w = 3'(i);
    end
    return w;
  endfunction

  function automatic logic [N_SRC-1:0] onehot(input logic [2:0] idx);
    logic [N_SRC-1:0] v;
    v = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (3'(i) == idx) v[i] = 1'b1;
    end
    return v;
  endfunction

`ifdef IRQC_EDGE_EN
  logic [N_SRC-1:0] prevIrq_q;

  // Previous irqIn sample for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst) prevIrq_q <= '0;
    else      prevIrq_q <= bus.irqIn;
  end

  assign set_vec = bus.irqIn & ~prevIrq_q;
`else
  assign set_vec = bus.irqIn;
`endif

  assign unused_data = ^bus.dataIn[31:N_SRC];
  assign cand        = pending_q & enable_q;
  assign win         = pick_winner(cand);
  assign eoi         = bus.write && (bus.addr == A_EOI);
  // An acknowledge only counts in REQ while something is still requesting.
  assign ack_take    = (state_q == REQ) && (cand != '0) && bus.intAck;
  assign ack_clr     = ack_take ? onehot(win) : '0;
  assign w1c         = (bus.write && (bus.addr == A_PENDING)) ? bus.dataIn[N_SRC-1:0] : '0;

  // Register next-state: set beats any same-cycle clear; reads use pre-write values.
  always_comb begin
    enable_d  = enable_q;
    pending_d = set_vec | (pending_q & ~(w1c | ack_clr));
    dataOut_d = dataOut_q;
    if (bus.write && (bus.addr == A_ENABLE)) enable_d = bus.dataIn[N_SRC-1:0];
    if (bus.read) begin
      dataOut_d = '0;
      case (bus.addr)
        A_ENABLE:  dataOut_d[N_SRC-1:0] = enable_q;
        A_PENDING: dataOut_d[N_SRC-1:0] = pending_q;
        A_ID:      if (state_q == SERVICE) dataOut_d = {1'b1, 28'b0, id_q};
        default:   dataOut_d = '0;
      endcase
    end
  end

  // FSM next-state, in-service id latch and EOI strobe.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    srcRead_d = '0;
    case (state_q)
      IDLE: begin
        if (cand != '0) state_d = REQ;
      end
      REQ: begin
        if (cand == '0) begin
          state_d = IDLE;
        end else if (bus.intAck) begin
          id_d    = win;
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (eoi) begin
          srcRead_d = onehot(id_q);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and register update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      enable_q  <= '0;
      pending_q <= '0;
      srcRead_q <= '0;
      id_q      <= 3'd0;
      dataOut_q <= '0;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      pending_q <= pending_d;
      srcRead_q <= srcRead_d;
      id_q      <= id_d;
      dataOut_q <= dataOut_d;
    end
  end

  assign bus.cpuIRQ  = (state_q == REQ);
  assign bus.srcRead = srcRead_q;
  assign bus.dataOut = dataOut_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller; register reads go through an
// expected-value queue that is popped when dataOut becomes valid.
module tb_irq_controller;

  localparam int N = 4;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  irq_controller_if #(.N_SRC(N)) bus ();

  irq_controller #(.N_SRC(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.write  = 1'b1;
    bus.addr   = a;
    bus.dataIn = d;
    tick();
    bus.write  = 1'b0;
    bus.dataIn = '0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    exp_t e;
    sb.push_back('{tag, exp});
    bus.read = 1'b1;
    bus.addr = a;
    tick();
    bus.read = 1'b0;
    e = sb.pop_front();
    chk(e.tag, bus.dataOut, e.exp);
  endtask

  task automatic pulse(input logic [N-1:0] m);
    bus.irqIn = bus.irqIn | m;
    tick();
    bus.irqIn = bus.irqIn & ~m;
  endtask

  task automatic ack();
    bus.intAck = 1'b1;
    tick();
    bus.intAck = 1'b0;
  endtask

  initial begin
    bus.irqIn  = '0;
    bus.read   = 1'b0;
    bus.write  = 1'b0;
    bus.addr   = 2'd0;
    bus.dataIn = '0;
    bus.intAck = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_cpuIRQ", 32'(bus.cpuIRQ), 32'd0);
    chk("rst_srcRead", 32'(bus.srcRead), 32'd0);
    chk("rst_dataOut", bus.dataOut, 32'd0);
    rst = 1'b1;
    rd("rst_enable", 2'd0, 32'd0);
    rd("rst_pending", 2'd1, 32'd0);
    rd("rst_id", 2'd2, 32'd0);

    // single source
    wr(2'd0, 32'h1);
    pulse(4'b0001);
    chk("single_lat1", 32'(bus.cpuIRQ), 32'd0);
    tick();
    chk("single_req", 32'(bus.cpuIRQ), 32'd1);
    ack();
    chk("single_ackdrop", 32'(bus.cpuIRQ), 32'd0);
    rd("single_id", 2'd2, 32'h8000_0000);
    rd("single_pend", 2'd1, 32'd0);
    wr(2'd3, 32'h0);
    chk("single_srcRead", 32'(bus.srcRead), 32'h1);
    tick();
    chk("single_srcRead_off", 32'(bus.srcRead), 32'h0);
    chk("single_idle", 32'(bus.cpuIRQ), 32'd0);
    rd("single_id_idle", 2'd2, 32'd0);

    // priority
    wr(2'd0, 32'hF);
    pulse(4'b0110);
    tick();
    chk("prio_req", 32'(bus.cpuIRQ), 32'd1);
    ack();
    rd("prio_id1", 2'd2, 32'h8000_0001);
    rd("prio_pend", 2'd1, 32'h4);
    wr(2'd3, 32'h0);
    chk("prio_srcRead1", 32'(bus.srcRead), 32'h2);
    tick();
    chk("prio_rereq", 32'(bus.cpuIRQ), 32'd1);
    ack();
    rd("prio_id2", 2'd2, 32'h8000_0002);
    wr(2'd3, 32'h0);
    chk("prio_srcRead2", 32'(bus.srcRead), 32'h4);
    tick();
    chk("prio_done", 32'(bus.cpuIRQ), 32'd0);

    // masking
    wr(2'd0, 32'h0);
    pulse(4'b1000);
    tick();
    chk("mask_noreq", 32'(bus.cpuIRQ), 32'd0);
    rd("mask_pend", 2'd1, 32'h8);
    wr(2'd0, 32'h8);
    tick();
    chk("mask_unmask_req", 32'(bus.cpuIRQ), 32'd1);
    wr(2'd0, 32'h0);
    tick();
    chk("mask_remask_drop", 32'(bus.cpuIRQ), 32'd0);
    wr(2'd1, 32'h8);
    rd("mask_w1c", 2'd1, 32'h0);

    // simultaneous set and write-1-clear
    bus.irqIn  = 4'b0001;
    bus.write  = 1'b1;
    bus.addr   = 2'd1;
    bus.dataIn = 32'h1;
    tick();
    bus.irqIn  = '0;
    bus.write  = 1'b0;
    bus.dataIn = '0;
    rd("sim_set_wins", 2'd1, 32'h1);

    // read and write same address: read returns old ENABLE
    sb.push_back('{"rw_same_addr", 32'h0});
    bus.read   = 1'b1;
    bus.write  = 1'b1;
    bus.addr   = 2'd0;
    bus.dataIn = 32'h1;
    tick();
    bus.read   = 1'b0;
    bus.write  = 1'b0;
    bus.dataIn = '0;
    begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, bus.dataOut, e.exp);
    end
    tick();
    chk("eoi_req_setup", 32'(bus.cpuIRQ), 32'd1);
    wr(2'd3, 32'h0);
    chk("eoi_in_req_srcRead", 32'(bus.srcRead), 32'h0);
    chk("eoi_in_req_state", 32'(bus.cpuIRQ), 32'd1);
    rd("id_in_req", 2'd2, 32'd0);

    // reset mid-SERVICE
    ack();
    rd("svc_id", 2'd2, 32'h8000_0000);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_cpuIRQ", 32'(bus.cpuIRQ), 32'd0);
    chk("mid_rst_srcRead", 32'(bus.srcRead), 32'd0);
    chk("mid_rst_dataOut", bus.dataOut, 32'd0);
    rd("mid_rst_pend", 2'd1, 32'd0);
    rd("mid_rst_enable", 2'd0, 32'd0);
    rd("mid_rst_id", 2'd2, 32'd0);

    // acknowledge outside REQ is ignored
    ack();
    chk("stray_ack", 32'(bus.cpuIRQ), 32'd0);
    rd("stray_ack_id", 2'd2, 32'd0);

    // ENABLE upper bits read 0
    wr(2'd0, 32'hFFFF_FFFF);
    rd("enable_upper", 2'd0, 32'hF);

    // source held high through EOI
    bus.irqIn = 4'b0001;
    tick();
    tick();
    chk("hold_req", 32'(bus.cpuIRQ), 32'd1);
    ack();
    wr(2'd3, 32'h0);
    chk("hold_srcRead", 32'(bus.srcRead), 32'h1);
    tick();
`ifdef IRQC_EDGE_EN
    chk("hold_no_retrigger", 32'(bus.cpuIRQ), 32'd0);
    rd("hold_pend", 2'd1, 32'h0);
`else
    chk("hold_level_rereq", 32'(bus.cpuIRQ), 32'd1);
    rd("hold_pend", 2'd1, 32'h1);
`endif
    bus.irqIn = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
